// File: rtl/xio_bus_rx.sv
// xio parallel bus receiver: synchronises the pin-level frame, decodes the
// command byte plus optional big-endian payload, and buffers one command word.
`ifndef XIO_CMD_SDRAM_READ
`define XIO_CMD_SDRAM_READ 4'h5
`endif

module xio_bus_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rData,
  input  logic        rRts,
  input  logic        rClk,
  output logic        rCts,
  output logic [3:0]  cmd,
  output logic [31:0] data,
  output logic        cmdValid,
  input  logic        cmdReady,
  output logic        frameErr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ACCEPT   = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] WAIT_END = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;

  logic [SYNC_STAGES-1:0]      rtsSync;
  logic [SYNC_STAGES-1:0]      clkSync;
  logic [SYNC_STAGES-1:0][7:0] dataSync;
  logic                        clkPrev;

  logic       rtsS;
  logic       clkS;
  logic [7:0] byteS;
  logic       strobe;

  logic [2:0]    state;
  logic [3:0]    cmdSh;
  logic [31:0]   dataSh;
  logic [1:0]    byteCnt;
  logic [TW-1:0] tCnt;
  logic          timeoutHit;
  logic          abort;

  // All three pin groups share the same depth so a byte lines up with its strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtsSync  <= '0;
      clkSync  <= '0;
      dataSync <= '0;
      clkPrev  <= 1'b0;
    end else begin
      rtsSync  <= {rtsSync[SYNC_STAGES-2:0], rRts};
      clkSync  <= {clkSync[SYNC_STAGES-2:0], rClk};
      dataSync <= {dataSync[SYNC_STAGES-2:0], rData};
      clkPrev  <= clkSync[SYNC_STAGES-1];
    end
  end

  assign rtsS   = rtsSync[SYNC_STAGES-1];
  assign clkS   = clkSync[SYNC_STAGES-1];
  assign byteS  = dataSync[SYNC_STAGES-1];
  assign strobe = clkS & ~clkPrev;

  assign timeoutHit = (TIMEOUT != 0) &&
                      (tCnt == TW'(TIMEOUT - 1));

  // A strobe always wins over rRts low in the same cycle
  always_comb begin
    abort = 1'b0;
    unique case (state)
      ACCEPT: begin
        if (strobe) abort = (byteS[7:4] != 4'h0);
        else        abort = !rtsS || timeoutHit;
      end
      DATA: begin
        if (!strobe) abort = !rtsS || timeoutHit;
      end
      WAIT_END: begin
        if (strobe)    abort = 1'b1;
        else if (rtsS) abort = timeoutHit;
      end
      default: abort = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rCts     <= 1'b0;
      cmd      <= 4'h0;
      data     <= 32'h0;
      cmdValid <= 1'b0;
      frameErr <= 1'b0;
      cmdSh    <= 4'h0;
      dataSh   <= 32'h0;
      byteCnt  <= 2'd0;
      tCnt     <= '0;
    end else begin
      frameErr <= abort;
      if (cmdValid && cmdReady) cmdValid <= 1'b0;
      if (abort) begin
        rCts    <= 1'b0;
        state   <= DRAIN;
        byteCnt <= 2'd0;
        tCnt    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rtsS && !cmdValid) begin
              state   <= ACCEPT;
              rCts    <= 1'b1;
              dataSh  <= 32'h0;
              byteCnt <= 2'd0;
              tCnt    <= '0;
            end
          end
          ACCEPT: begin
            if (strobe) begin
              cmdSh <= byteS[3:0];
              tCnt  <= '0;
              if (byteS[3:0] == `XIO_CMD_SDRAM_READ)
                state <= DATA;
              else
                state <= WAIT_END;
            end else begin
              tCnt <= tCnt + TW'(1);
            end
          end
          DATA: begin
            if (strobe) begin
              dataSh  <= {dataSh[23:0], byteS};
              byteCnt <= byteCnt + 2'd1;
              tCnt    <= '0;
              if (byteCnt == 2'd3) state <= WAIT_END;
            end else begin
              tCnt <= tCnt + TW'(1);
            end
          end
          WAIT_END: begin
            if (!rtsS) begin
              rCts     <= 1'b0;
              cmdValid <= 1'b1;
              cmd      <= cmdSh;
              data     <= dataSh;
              state    <= IDLE;
              tCnt     <= '0;
            end else begin
              tCnt <= tCnt + TW'(1);
            end
          end
          DRAIN: begin
            rCts <= 1'b0;
            if (!rtsS) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
